otter_mc_control_unit: RTL and testbench

Parametrised next-generation multicycle control FSM for the OTTER core with L1 caches. It sequences fetch, execute, cache-wait, writeback, interrupt and trap states, driven by cache valid handshakes. Over the previous generation it adds:
- An internal interrupt-pending latch.
- Exception traps for illegal opcode, ECALL, EBREAK and cache timeout, with a cause code.
- A configurable memory timeout.
- A saturating stall-cycle performance counter.

It sits between the IR/decoder and the PC, regfile, CSR and cache control signals.

---
 rtl/otter_cu_pkg.sv | 48 ++++
 rtl/otter_cu_decode.sv | 57 +++++
 rtl/otter_mc_control_unit.sv | 172 +++++++++++++++++
 tb/tb_otter_mc_control_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/otter_cu_pkg.sv
// Shared encodings for the OTTER multicycle control unit: opcodes, system funct3,
// FSM states and mcause values.
package otter_cu_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      F3_PRIV   = 3'b000,
      F3_CSRRW  = 3'b001,
      F3_CSRRS  = 3'b010,
      F3_CSRRC  = 3'b011,
      F3_CSRRWI = 3'b101,
      F3_CSRRSI = 3'b110,
      F3_CSRRCI = 3'b111
   } funct3_system_t;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXEC  = 3'd1,
      ST_MEM   = 3'd2,
      ST_WB    = 3'd3,
      ST_INTER = 3'd4,
      ST_TRAP  = 3'd5
   } state_t;

   localparam logic [3:0] CAUSE_IFETCH_FAULT = 4'd1;
   localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
   localparam logic [3:0] CAUSE_BREAK        = 4'd3;
   localparam logic [3:0] CAUSE_LOAD_FAULT   = 4'd5;
   localparam logic [3:0] CAUSE_STORE_FAULT  = 4'd7;
   localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

   localparam logic [11:0] FUNC12_ECALL  = 12'h000;
   localparam logic [11:0] FUNC12_EBREAK = 12'h001;
   localparam logic [11:0] FUNC12_MRET   = 12'h302;

endpackage

// File: rtl/otter_cu_decode.sv
// Combinational instruction classifier: memory/branch/MRET/CSRRW flags plus
// synchronous-exception detection with its mcause code.
module otter_cu_decode
   import otter_cu_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [11:0] func12,
   output logic        is_load,
   output logic        is_store,
   output logic        is_branch,
   output logic        is_mret,
   output logic        is_csrrw,
   output logic        exc_valid,
   output logic [3:0]  exc_cause
);

   logic legal;
   logic is_priv;

   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_priv   = (opcode == OPC_SYSTEM) && (func3 == F3_PRIV);
   assign is_mret   = is_priv && (func12 == FUNC12_MRET);
   assign is_csrrw  = (opcode == OPC_SYSTEM) && (func3 == F3_CSRRW);

   always_comb begin
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: legal = 1'b1;
         default:                                               legal = 1'b0;
      endcase
   end

   // Illegal opcode outranks the privileged-instruction checks.
   always_comb begin
      exc_valid = 1'b0;
      exc_cause = 4'd0;
      if (!legal) begin
         exc_valid = 1'b1;
         exc_cause = CAUSE_ILLEGAL;
      end else if (is_priv) begin
         if (func12 == FUNC12_ECALL) begin
            exc_valid = 1'b1;
            exc_cause = CAUSE_ECALL_M;
         end else if (func12 == FUNC12_EBREAK) begin
            exc_valid = 1'b1;
            exc_cause = CAUSE_BREAK;
         end else if (func12 != FUNC12_MRET) begin
            exc_valid = 1'b1;
            exc_cause = CAUSE_ILLEGAL;
         end
      end
   end

endmodule

// File: rtl/otter_mc_control_unit.sv
// Multicycle OTTER control FSM with cache handshakes, interrupt-pending latch,
// synchronous traps, access timeout and a saturating stall-cycle counter.
module otter_mc_control_unit
   import otter_cu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 32,
   parameter int INT_EN         = 1
) (
   input  logic             CU_CLK,
   input  logic             CU_RESET_N,
   input  logic             CU_INT,
   input  logic [6:0]       CU_OPCODE,
   input  logic [2:0]       CU_FUNC3,
   input  logic [11:0]      CU_FUNC12,
   input  logic             MEM_VALID1,
   input  logic             MEM_VALID2,
   output logic             CU_PCWRITE,
   output logic             CU_REGWRITE,
   output logic             CU_MEMREAD1,
   output logic             CU_MEMREAD2,
   output logic             CU_MEMWRITE,
   output logic             CU_csrWrite,
   output logic             CU_intTaken,
   output logic             CU_intCLR,
   output logic             CU_trapTaken,
   output logic [3:0]       CU_trapCause,
   output logic [CNT_W-1:0] CU_stallCount,
   output logic [2:0]       CU_state
);

   localparam int WAIT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TO_LAST);

   state_t            state, state_nx;
   logic              pending;
   logic [3:0]        cause_q, cause_nx;
   logic [WAIT_W-1:0] wait_q;
   logic [CNT_W-1:0]  stall_q;

   logic is_load, is_store, is_branch, is_mret, is_csrrw, exc_valid;
   logic [3:0] exc_cause;
   logic timeout, stall_cyc;
   state_t ret_nx;

   otter_cu_decode u_decode (
      .opcode    (CU_OPCODE),
      .func3     (CU_FUNC3),
      .func12    (CU_FUNC12),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_branch (is_branch),
      .is_mret   (is_mret),
      .is_csrrw  (is_csrrw),
      .exc_valid (exc_valid),
      .exc_cause (exc_cause)
   );

   assign timeout   = (TIMEOUT_CYCLES != 0) && (wait_q == WAIT_LAST);
   assign stall_cyc = ((state == ST_FETCH) && !MEM_VALID1) ||
                      ((state == ST_MEM)   && !MEM_VALID2);
   assign ret_nx    = pending ? ST_INTER : ST_FETCH;

   always_comb begin
      state_nx     = state;
      cause_nx     = cause_q;
      CU_PCWRITE   = 1'b0;
      CU_REGWRITE  = 1'b0;
      CU_MEMREAD1  = 1'b0;
      CU_MEMREAD2  = 1'b0;
      CU_MEMWRITE  = 1'b0;
      CU_csrWrite  = 1'b0;
      CU_intTaken  = 1'b0;
      CU_intCLR    = 1'b0;
      CU_trapTaken = 1'b0;
      CU_trapCause = 4'd0;
      case (state)
         ST_FETCH: begin
            CU_MEMREAD1 = 1'b1;
            if (MEM_VALID1) begin
               state_nx = ST_EXEC;
            end else if (timeout) begin
               state_nx = ST_TRAP;
               cause_nx = CAUSE_IFETCH_FAULT;
            end
         end
         ST_EXEC: begin
            // Exceptions win over a pending interrupt and suppress all writes.
            if (exc_valid) begin
               state_nx = ST_TRAP;
               cause_nx = exc_cause;
            end else if (is_load || is_store) begin
               state_nx = ST_MEM;
            end else begin
               CU_PCWRITE  = 1'b1;
               CU_REGWRITE = !(is_branch || is_mret);
               CU_csrWrite = is_csrrw;
               CU_intCLR   = 1'b1;
               state_nx    = ret_nx;
            end
         end
         ST_MEM: begin
            CU_MEMREAD2 = is_load;
            CU_MEMWRITE = is_store;
            if (MEM_VALID2) begin
               if (is_load) begin
                  state_nx = ST_WB;
               end else begin
                  CU_PCWRITE = 1'b1;
                  CU_intCLR  = 1'b1;
                  state_nx   = ret_nx;
               end
            end else if (timeout) begin
               state_nx = ST_TRAP;
               cause_nx = is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
            end
         end
         ST_WB: begin
            CU_REGWRITE = 1'b1;
            CU_PCWRITE  = 1'b1;
            CU_intCLR   = 1'b1;
            state_nx    = ret_nx;
         end
         ST_INTER: begin
            CU_intTaken = 1'b1;
            CU_PCWRITE  = 1'b1;
            CU_intCLR   = 1'b1;
            state_nx    = ST_FETCH;
         end
         ST_TRAP: begin
            CU_trapTaken = 1'b1;
            CU_PCWRITE   = 1'b1;
            CU_trapCause = cause_q;
            state_nx     = ST_FETCH;
         end
         default: state_nx = ST_FETCH;
      endcase
   end

   always_ff @(posedge CU_CLK or negedge CU_RESET_N) begin
      if (!CU_RESET_N) begin
         state   <= ST_FETCH;
         cause_q <= 4'd0;
      end else begin
         state   <= state_nx;
         cause_q <= cause_nx;
      end
   end

   // A still-asserted request re-arms the latch in the same cycle INTER clears it.
   always_ff @(posedge CU_CLK or negedge CU_RESET_N) begin
      if (!CU_RESET_N)                pending <= 1'b0;
      else if ((INT_EN != 0) && CU_INT) pending <= 1'b1;
      else if (state == ST_INTER)     pending <= 1'b0;
   end

   always_ff @(posedge CU_CLK or negedge CU_RESET_N) begin
      if (!CU_RESET_N)             wait_q <= '0;
      else if (state_nx != state)  wait_q <= '0;
      else if (stall_cyc)          wait_q <= wait_q + 1'b1;
   end

   always_ff @(posedge CU_CLK or negedge CU_RESET_N) begin
      if (!CU_RESET_N)                       stall_q <= '0;
      else if (stall_cyc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
   end

   assign CU_stallCount = stall_q;
   assign CU_state      = state;

endmodule

// File: tb/tb_otter_mc_control_unit.sv
// Directed-vector bench for otter_mc_control_unit (short timeout, 4-bit stall counter).
module tb_otter_mc_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [11:0] f12;
   logic        v1, v2;
   logic        pcw, rw, mr1, mr2, mw, csrw, itk, iclr, ttk;
   logic [3:0]  tcause;
   logic [3:0]  stall;
   logic [2:0]  st;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   otter_mc_control_unit #(.TIMEOUT_CYCLES(4), .CNT_W(4), .INT_EN(1)) dut (
      .CU_CLK(clk), .CU_RESET_N(rst_n), .CU_INT(irq),
      .CU_OPCODE(opc), .CU_FUNC3(f3), .CU_FUNC12(f12),
      .MEM_VALID1(v1), .MEM_VALID2(v2),
      .CU_PCWRITE(pcw), .CU_REGWRITE(rw), .CU_MEMREAD1(mr1), .CU_MEMREAD2(mr2),
      .CU_MEMWRITE(mw), .CU_csrWrite(csrw), .CU_intTaken(itk), .CU_intCLR(iclr),
      .CU_trapTaken(ttk), .CU_trapCause(tcause), .CU_stallCount(stall), .CU_state(st)
   );

   task automatic set_inst(input logic [6:0] o, input logic [2:0] a, input logic [11:0] b);
      opc = o; f3 = a; f12 = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; irq = 1'b0; v1 = 1'b0; v2 = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; irq = 1'b0; v1 = 1'b0; v2 = 1'b0; set_inst(7'h13, 3'd0, 12'h0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", st); end
      n_checks++; if (mr1 !== 1'b1) begin n_fail++; $display("FAIL rst_memread1: got %b want 1", mr1); end
      n_checks++; if ({pcw, rw, mr2, mw, csrw, itk, iclr, ttk} !== 8'h00) begin n_fail++; $display("FAIL rst_enables: got %b want 00000000", {pcw, rw, mr2, mw, csrw, itk, iclr, ttk}); end
      @(negedge clk); @(negedge clk);
      n_checks++; if (stall !== 4'd0) begin n_fail++; $display("FAIL rst_stall: got %0d want 0", stall); end
      n_checks++; if (tcause !== 4'd0) begin n_fail++; $display("FAIL rst_cause: got %0d want 0", tcause); end
   endtask

   task automatic test_alu();
      do_reset();
      set_inst(7'b0010011, 3'd0, 12'h005); v1 = 1'b0; #1;
      n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL alu_fetch1: got %0d want 0", st); end
      @(negedge clk); v1 = 1'b1; #1;
      n_checks++; if (st !== 3'd0 || mr1 !== 1'b1) begin n_fail++; $display("FAIL alu_fetch2: got st=%0d mr1=%b want st=0 mr1=1", st, mr1); end
      @(negedge clk); v1 = 1'b0; #1;
      n_checks++; if (st !== 3'd1 || rw !== 1'b1 || pcw !== 1'b1 || iclr !== 1'b1) begin n_fail++; $display("FAIL alu_exec: got st=%0d rw=%b pcw=%b iclr=%b want 1 1 1 1", st, rw, pcw, iclr); end
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL alu_back: got %0d want 0", st); end
      n_checks++; if (stall !== 4'd1) begin n_fail++; $display("FAIL alu_stall: got %0d want 1", stall); end
   endtask

   task automatic test_load();
      do_reset();
      set_inst(7'b0000011, 3'd2, 12'h0); v1 = 1'b1; #1;
      @(negedge clk); v1 = 1'b0; #1;
      n_checks++; if (st !== 3'd1 || pcw !== 1'b0 || rw !== 1'b0) begin n_fail++; $display("FAIL ld_exec: got st=%0d pcw=%b rw=%b want 1 0 0", st, pcw, rw); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); v2 = (i == 3); #1;
         n_checks++; if (st !== 3'd2 || mr2 !== 1'b1 || mw !== 1'b0) begin n_fail++; $display("FAIL ld_mem%0d: got st=%0d mr2=%b mw=%b want 2 1 0", i, st, mr2, mw); end
      end
      @(negedge clk); v2 = 1'b0; #1;
      n_checks++; if (st !== 3'd3 || rw !== 1'b1 || pcw !== 1'b1) begin n_fail++; $display("FAIL ld_wb: got st=%0d rw=%b pcw=%b want 3 1 1", st, rw, pcw); end
      n_checks++; if (stall !== 4'd3) begin n_fail++; $display("FAIL ld_stall: got %0d want 3", stall); end
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL ld_back: got %0d want 0", st); end
   endtask

   task automatic test_store_timeout();
      do_reset();
      set_inst(7'b0100011, 3'd2, 12'h0); v1 = 1'b1; #1;
      @(negedge clk); v1 = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         n_checks++; if (st !== 3'd2 || mw !== 1'b1 || pcw !== 1'b0) begin n_fail++; $display("FAIL st_mem%0d: got st=%0d mw=%b pcw=%b want 2 1 0", i, st, mw, pcw); end
      end
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd5 || ttk !== 1'b1 || tcause !== 4'd7) begin n_fail++; $display("FAIL st_trap: got st=%0d ttk=%b cause=%0d want 5 1 7", st, ttk, tcause); end
      n_checks++; if (pcw !== 1'b1 || mw !== 1'b0 || rw !== 1'b0) begin n_fail++; $display("FAIL st_trap_en: got pcw=%b mw=%b rw=%b want 1 0 0", pcw, mw, rw); end
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd0 || tcause !== 4'd0) begin n_fail++; $display("FAIL st_back: got st=%0d cause=%0d want 0 0", st, tcause); end
   endtask

   task automatic test_exceptions();
      logic [6:0]  t_op  [8] = '{7'h7F, 7'h73, 7'h73, 7'h73, 7'h73, 7'h73, 7'h63, 7'h37};
      logic [2:0]  t_f3  [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
      logic [11:0] t_f12 [8] = '{12'h000, 12'h000, 12'h001, 12'h302, 12'h105, 12'h300, 12'h000, 12'h000};
      logic [3:0]  t_cau [8] = '{4'd2, 4'd11, 4'd3, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0};
      logic [2:0]  t_en  [8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b111, 3'b100, 3'b110};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_inst(t_op[i], t_f3[i], t_f12[i]); v1 = 1'b1; #1;
         @(negedge clk); v1 = 1'b0; #1;
         n_checks++; if (st !== 3'd1 || {pcw, rw, csrw} !== t_en[i]) begin n_fail++; $display("FAIL exc_exec%0d: got st=%0d pcw/rw/csr=%b want 1 %b", i, st, {pcw, rw, csrw}, t_en[i]); end
         @(negedge clk); #1;
         if (t_cau[i] != 4'd0) begin
            n_checks++; if (st !== 3'd5 || ttk !== 1'b1 || tcause !== t_cau[i]) begin n_fail++; $display("FAIL exc_trap%0d: got st=%0d ttk=%b cause=%0d want 5 1 %0d", i, st, ttk, tcause, t_cau[i]); end
            @(negedge clk);
         end else begin
            n_checks++; if (st !== 3'd0 || ttk !== 1'b0) begin n_fail++; $display("FAIL exc_ret%0d: got st=%0d ttk=%b want 0 0", i, st, ttk); end
         end
      end
   endtask

   task automatic test_interrupt();
      do_reset();
      set_inst(7'b0110011, 3'd0, 12'h0); v1 = 1'b0; irq = 1'b1; #1;
      @(negedge clk); irq = 1'b0; v1 = 1'b1; #1;
      @(negedge clk); v1 = 1'b0; #1;
      n_checks++; if (st !== 3'd1 || itk !== 1'b0 || iclr !== 1'b1) begin n_fail++; $display("FAIL int_exec: got st=%0d itk=%b iclr=%b want 1 0 1", st, itk, iclr); end
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd4 || itk !== 1'b1 || pcw !== 1'b1) begin n_fail++; $display("FAIL int_inter: got st=%0d itk=%b pcw=%b want 4 1 1", st, itk, pcw); end
      @(negedge clk); v1 = 1'b1; #1;
      n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL int_fetch: got %0d want 0", st); end
      @(negedge clk); v1 = 1'b0; #1;
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL int_cleared: got %0d want 0", st); end
      // ECALL with an interrupt pending: trap first, interrupt after the next instruction
      set_inst(7'b1110011, 3'd0, 12'h000); v1 = 1'b1; irq = 1'b1; #1;
      @(negedge clk); v1 = 1'b0; irq = 1'b0; #1;
      n_checks++; if (st !== 3'd1 || pcw !== 1'b0 || iclr !== 1'b0) begin n_fail++; $display("FAIL ecall_exec: got st=%0d pcw=%b iclr=%b want 1 0 0", st, pcw, iclr); end
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd5 || itk !== 1'b0 || tcause !== 4'd11) begin n_fail++; $display("FAIL ecall_trap: got st=%0d itk=%b cause=%0d want 5 0 11", st, itk, tcause); end
      @(negedge clk); set_inst(7'b0110011, 3'd0, 12'h0); v1 = 1'b1; #1;
      @(negedge clk); v1 = 1'b0; #1;
      n_checks++; if (st !== 3'd1) begin n_fail++; $display("FAIL ecall_next: got %0d want 1", st); end
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd4 || itk !== 1'b1) begin n_fail++; $display("FAIL ecall_inter: got st=%0d itk=%b want 4 1", st, itk); end
      @(negedge clk); #1;
      n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL ecall_back: got %0d want 0", st); end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      set_inst(7'b0000011, 3'd2, 12'h0); v1 = 1'b1; #1;
      @(negedge clk); v1 = 1'b0; #1;
      @(negedge clk); #1;
      n_checks++; if (mr2 !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got mr2=%b want 1", mr2); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (mr2 !== 1'b0 || mr1 !== 1'b1 || st !== 3'd0) begin n_fail++; $display("FAIL rmid_async: got mr2=%b mr1=%b st=%0d want 0 1 0", mr2, mr1, st); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1; #1;
      n_checks++; if (st !== 3'd0 || mr1 !== 1'b1 || stall !== 4'd0) begin n_fail++; $display("FAIL rmid_after: got st=%0d mr1=%b stall=%0d want 0 1 0", st, mr1, stall); end
   endtask

   task automatic test_saturation();
      do_reset();
      set_inst(7'b0010011, 3'd0, 12'h0); v1 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (i == 4) begin
            n_checks++; if (st !== 3'd5 || tcause !== 4'd1) begin n_fail++; $display("FAIL ifetch_trap: got st=%0d cause=%0d want 5 1", st, tcause); end
         end
         @(negedge clk);
      end
      #1;
      n_checks++; if (stall !== 4'd15) begin n_fail++; $display("FAIL stall_sat: got %0d want 15", stall); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store_timeout();
      test_exceptions();
      test_interrupt();
      test_reset_mid_mem();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
